// File: rtl/exec_unit_if.sv
// Issue/write-back bus between the register file and the execute stage.
interface exec_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [AW-1:0]    rd_in;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             wb_write;
   logic [AW-1:0]    wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             illegal_op;

   // Upstream side: presents operations, observes write-back.
   modport master (
      output in_valid, op, rd_in, rs_val, rt_val,
      input  in_ready, wb_write, wb_rd, wb_data, illegal_op
   );

   // Execute unit side.
   modport slave (
      input  in_valid, op, rd_in, rs_val, rt_val,
      output in_ready, wb_write, wb_rd, wb_data, illegal_op
   );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus iterative 32-cycle MUL / DIVU / REMU,
// sharing one valid/ready issue port and one registered write-back port.
module exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 6
) (
   input  logic       clk,
   input  logic       rst,
   exec_unit_if.slave bus
);

   localparam int unsigned      CNT_W    = 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_DIVU = 4'd10;
   localparam logic [3:0] OP_REMU = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;      // multiplicand / dividend-then-quotient
   logic [WIDTH-1:0] b_q, b_d;      // multiplier / divisor
   logic [WIDTH-1:0] acc_q, acc_d;  // product accumulator / partial remainder
   logic [AW-1:0]    rd_q, rd_d;
   logic             rem_q, rem_d;  // divide returns remainder instead of quotient
   logic             wb_write_q, wb_write_d;
   logic [AW-1:0]    wb_rd_q, wb_rd_d;
   logic [WIDTH-1:0] wb_data_q, wb_data_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] alu_res;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic             q_bit;
   logic [WIDTH-1:0] div_acc;
   logic [WIDTH-1:0] div_quo;

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.wb_write   = wb_write_q;
   assign bus.wb_rd      = wb_rd_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.illegal_op = illegal_q;

   // Single-cycle ALU result for ops 0-8.
   always_comb begin
      alu_res = '0;
      shamt   = bus.rt_val[4:0];
      case (bus.op)
         OP_ADD:  alu_res = bus.rs_val + bus.rt_val;
         OP_SUB:  alu_res = bus.rs_val - bus.rt_val;
         OP_AND:  alu_res = bus.rs_val & bus.rt_val;
         OP_OR:   alu_res = bus.rs_val | bus.rt_val;
         OP_XOR:  alu_res = bus.rs_val ^ bus.rt_val;
         OP_SLT:  alu_res = WIDTH'($signed(bus.rs_val) < $signed(bus.rt_val));
         OP_SLL:  alu_res = bus.rs_val << shamt;
         OP_SRL:  alu_res = bus.rs_val >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(bus.rs_val) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   // One shift-add multiply step and one restoring-divide step.
   always_comb begin
      mul_sum  = acc_q + (b_q[0] ? a_q : '0);
      rem_sh   = {acc_q, a_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      q_bit    = ~rem_diff[WIDTH];   // no borrow: shifted remainder >= divisor
      div_acc  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      div_quo  = {a_q[WIDTH-2:0], q_bit};
   end

   // Next-state, datapath update and write-back selection.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      rd_d       = rd_q;
      rem_d      = rem_q;
      wb_write_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               case (bus.op)
                  OP_MUL: begin
                     a_d     = bus.rs_val;
                     b_d     = bus.rt_val;
                     acc_d   = '0;
                     rd_d    = bus.rd_in;
                     cnt_d   = '0;
                     state_d = S_MUL;
                  end
                  OP_DIVU, OP_REMU: begin
                     if (bus.rt_val == '0) begin
                        wb_write_d = 1'b1;
                        wb_rd_d    = bus.rd_in;
                        wb_data_d  = (bus.op == OP_DIVU) ? '1 : bus.rs_val;
                     end else begin
                        a_d     = bus.rs_val;
                        b_d     = bus.rt_val;
                        acc_d   = '0;
                        rd_d    = bus.rd_in;
                        rem_d   = (bus.op == OP_REMU);
                        cnt_d   = '0;
                        state_d = S_DIV;
                     end
                  end
                  default: begin
                     if (bus.op <= OP_SRA) begin
                        wb_write_d = 1'b1;
                        wb_rd_d    = bus.rd_in;
                        wb_data_d  = alu_res;
                     end else begin
                        illegal_d = 1'b1;
                     end
                  end
               endcase
            end
         end
         S_MUL: begin
            acc_d = mul_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               wb_write_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = mul_sum;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end
         end
         S_DIV: begin
            acc_d = div_acc;
            a_d   = div_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               wb_write_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = rem_q ? div_acc : div_quo;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         rd_q       <= '0;
         rem_q      <= 1'b0;
         wb_write_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         rd_q       <= rd_d;
         rem_q      <= rem_d;
         wb_write_q <= wb_write_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, iterative MUL/DIV, divide by zero,
// illegal opcode and reset behaviour.
module tb_exec_unit;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_DIVU = 4'd10;
   localparam logic [3:0] OP_REMU = 4'd11;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   exec_unit_if #(.WIDTH(32), .AW(6)) bus ();

   exec_unit #(.WIDTH(32), .AW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [5:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      bus.op       = op;
      bus.rd_in    = rd;
      bus.rs_val   = a;
      bus.rt_val   = b;
      bus.in_valid = 1'b1;
   endtask

   // Issue one single-cycle op and check its write-back in the following half cycle.
   task automatic single(input string tag, input logic [3:0] op, input logic [5:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      drive(op, rd, a, b);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_wr"},   32'(bus.wb_write), 32'd1);
      chk({tag, "_rd"},   32'(bus.wb_rd),    32'(rd));
      chk({tag, "_data"}, bus.wb_data,       exp);
   endtask

   // Issue an iterative op while holding in_valid high with junk operands.
   task automatic multi(input string tag, input logic [3:0] op, input logic [5:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int lat;
      int ready_bad;
      lat       = -1;
      ready_bad = 0;
      drive(op, rd, a, b);
      @(posedge clk);
      #1;
      bus.op     = OP_ADD;
      bus.rd_in  = 6'd63;
      bus.rs_val = 32'h1111_1111;
      bus.rt_val = 32'h2222_2222;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (bus.wb_write === 1'b1) begin
            lat = n;
            break;
         end
         if (bus.in_ready !== 1'b0) ready_bad++;
      end
      bus.in_valid = 1'b0;
      chk({tag, "_lat"},   32'(lat),          32'd32);
      chk({tag, "_rd"},    32'(bus.wb_rd),    32'(rd));
      chk({tag, "_data"},  bus.wb_data,       exp);
      chk({tag, "_rdy"},   32'(bus.in_ready), 32'd1);
      chk({tag, "_busy"},  32'(ready_bad),    32'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.wb_write), 32'd0);
   endtask

   initial begin
      int wr_cnt;
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.op       = '0;
      bus.rd_in    = '0;
      bus.rs_val   = '0;
      bus.rt_val   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.in_ready),   32'd1);
      chk("rst_wr",    32'(bus.wb_write),   32'd0);
      chk("rst_rd",    32'(bus.wb_rd),      32'd0);
      chk("rst_data",  bus.wb_data,         32'd0);
      chk("rst_ill",   32'(bus.illegal_op), 32'd0);
      rst = 1'b0;

      // Back-to-back ADD then SUB.
      drive(OP_ADD, 6'd3, 32'd5, 32'd7);
      @(posedge clk);
      #1 drive(OP_SUB, 6'd4, 32'd3, 32'd5);
      @(negedge clk);
      chk("add_wr",   32'(bus.wb_write), 32'd1);
      chk("add_rd",   32'(bus.wb_rd),    32'd3);
      chk("add_data", bus.wb_data,       32'd12);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("sub_wr",   32'(bus.wb_write), 32'd1);
      chk("sub_rd",   32'(bus.wb_rd),    32'd4);
      chk("sub_data", bus.wb_data,       32'hFFFF_FFFE);
      @(negedge clk);
      chk("idle_wr",   32'(bus.wb_write), 32'd0);
      chk("hold_data", bus.wb_data,       32'hFFFF_FFFE);
      chk("hold_rd",   32'(bus.wb_rd),    32'd4);

      single("slt", OP_SLT, 6'd5,  32'hFFFF_FFFF, 32'd1,         32'd1);
      single("sra", OP_SRA, 6'd6,  32'h8000_0000, 32'd4,         32'hF800_0000);
      single("sll", OP_SLL, 6'd7,  32'd1,         32'h23,        32'd8);
      single("srl", OP_SRL, 6'd8,  32'h8000_0000, 32'd4,         32'h0800_0000);
      single("and", OP_AND, 6'd9,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
      single("or",  OP_OR,  6'd10, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0);
      single("xor", OP_XOR, 6'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);

      multi("mul",  OP_MUL,  6'd11, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
      multi("mulo", OP_MUL,  6'd12, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
      multi("divu", OP_DIVU, 6'd13, 32'd100,       32'd7,         32'd14);
      multi("remu", OP_REMU, 6'd14, 32'd100,       32'd7,         32'd2);

      single("div0", OP_DIVU, 6'd15, 32'd9, 32'd0, 32'hFFFF_FFFF);
      single("rem0", OP_REMU, 6'd16, 32'd9, 32'd0, 32'd9);

      // Illegal opcode.
      drive(4'd13, 6'd17, 32'd1, 32'd2);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
      chk("ill_wr",    32'(bus.wb_write),   32'd0);
      chk("ill_rdy",   32'(bus.in_ready),   32'd1);
      @(negedge clk);
      chk("ill_once",  32'(bus.illegal_op), 32'd0);

      // Reset in the middle of a divide abandons it.
      wr_cnt = 0;
      drive(OP_DIVU, 6'd20, 32'd100, 32'd7);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (11) begin
         @(negedge clk);
         if (bus.wb_write === 1'b1) wr_cnt++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_rdy", 32'(bus.in_ready), 32'd1);
      repeat (40) begin
         if (bus.wb_write === 1'b1) wr_cnt++;
         @(negedge clk);
      end
      chk("abort_nowr", 32'(wr_cnt), 32'd0);
      single("post_add", OP_ADD, 6'd21, 32'd40, 32'd2, 32'd42);

      // Reset wins over a simultaneous valid.
      rst = 1'b1;
      drive(OP_ADD, 6'd22, 32'd1, 32'd1);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rstv_wr",   32'(bus.wb_write), 32'd0);
      chk("rstv_data", bus.wb_data,       32'd0);
      chk("rstv_rd",   32'(bus.wb_rd),    32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
